// File: rtl/rv_pkg.sv
// rv_pkg: shared constants and types for the register-file writeback path.
//   XLEN   - data width of a register
//   NREGS  - architectural register count (x0 reads as zero)
//   REG_X0 - index of the hardwired zero register
//   wb_t   - one register-file write: destination index plus data
package rv_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] wd;
  } wb_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small circular buffer of writeback bundles.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   push       - write push_data at the clock edge (ignored while full)
//   push_data  - bundle to enqueue
//   pop        - drop the head entry at the clock edge (ignored while empty)
//   head       - oldest entry, valid whenever empty is low
//   full/empty - occupancy flags
//   count      - number of stored entries, 0..DEPTH
module wb_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  wb_t                          push_data,
  input  logic                         pop,
  output wb_t                          head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_t           mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage is not reset: pointers and count decide what is valid, so
  // clearing them is enough to discard the contents.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file's single write port between
// the core writeback path (always first) and buffered mul/div results, and
// tracks mul/div destinations still in flight so the core can stall.
// Ports:
//   clk, rst                   - clock, asynchronous active-high reset
//   core_we/core_rd/core_wd    - core writeback request
//   md_valid/md_rd/md_wd       - mul/div result offer; md_ready = FIFO not full
//   issue_valid/issue_rd       - mul/div issue; issue_stall blocks it
//   rs1/rs2                    - source queries; raw_stall if either pending
//   waw_stall                  - core write targets a pending register
//   reg_write/rd/wd            - register file write port
// XLEN and NREGS must match the rv_pkg values since the bundle type is shared.
module regfile_wb_arbiter
  import rv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = rv_pkg::XLEN,
  parameter int NREGS = rv_pkg::NREGS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            core_we,
  input  logic [4:0]      core_rd,
  input  logic [XLEN-1:0] core_wd,
  input  logic            md_valid,
  output logic            md_ready,
  input  logic [4:0]      md_rd,
  input  logic [XLEN-1:0] md_wd,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic            issue_stall,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            raw_stall,
  output logic            waw_stall,
  output logic            reg_write,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] wd
);

  localparam int CW = $clog2(DEPTH + 1);

  wb_t             fifo_in;
  wb_t             fifo_head;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            fifo_push;
  logic            fifo_pop;
  logic            core_sel;
  logic            issue_set;
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_next;

  // A core write to x0 is not a real write, so that slot goes to the FIFO.
  assign core_sel = core_we && (core_rd != REG_X0);

  assign md_ready  = !fifo_full;
  // Results for x0 are accepted (handshake completes) but never stored.
  assign fifo_push = md_valid && md_ready && (md_rd != REG_X0);
  assign fifo_pop  = !core_sel && !fifo_empty;
  assign fifo_in   = '{rd: md_rd, wd: md_wd};

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Write-port mux: core first, then FIFO head, otherwise an idle port
  // with zeroed address and data.
  always_comb begin
    reg_write = 1'b0;
    rd        = REG_X0;
    wd        = '0;
    if (core_sel) begin
      reg_write = 1'b1;
      rd        = core_rd;
      wd        = core_wd;
    end else if (!fifo_empty) begin
      reg_write = 1'b1;
      rd        = fifo_head.rd;
      wd        = fifo_head.wd;
    end
  end

  // Stalls look only at the registered pending bits; a clear at this edge
  // is visible from the next cycle on.
  assign issue_stall = pending[issue_rd];
  assign raw_stall   = pending[rs1] || pending[rs2];
  assign waw_stall   = core_we && pending[core_rd];
  assign issue_set   = issue_valid && (issue_rd != REG_X0) && !issue_stall;

  // Clear first, then set, so a set to the same index wins.
  always_comb begin
    pending_next = pending;
    if (fifo_pop) begin
      pending_next[fifo_head.rd] = 1'b0;
    end
    if (issue_set) begin
      pending_next[issue_rd] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  // Occupancy can never exceed the buffer size.
  count_in_range: assert property (@(posedge clk) disable iff (rst)
    fifo_count <= CW'(DEPTH));

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between the single-cycle core writeback path and a multi-cycle mul/div unit (RV32M).
- Buffers mul/div results in a small FIFO and drains them into idle write-port cycles; the core writeback always has priority.
- Keeps a pending-write scoreboard so the core can stall on RAW and WAW hazards against mul/div destinations still in flight.
- Sits between the core datapath, the mul/div unit and the register file's reg_write/rd/wd inputs.

Parameters:
DEPTH, 2, result FIFO entries (power of 2, >=2)
XLEN, 32, data width
NREGS, 32, architectural register count (x0 hardwired zero)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
core_we  in  1  core writeback request this cycle
core_rd  in  5  core destination register
core_wd  in  XLEN  core writeback data
md_valid  in  1  mul/div result valid
md_ready  out  1  FIFO can accept a result (= !full)
md_rd  in  5  mul/div result destination
md_wd  in  XLEN  mul/div result data
issue_valid  in  1  mul/div op issued this cycle
issue_rd  in  5  destination of the issued op
issue_stall  out  1  pending[issue_rd] set; issue must not occur
rs1  in  5  source register query 1
rs2  in  5  source register query 2
raw_stall  out  1  pending[rs1] or pending[rs2]
waw_stall  out  1  core_we and pending[core_rd]
reg_write  out  1  to regfile write enable
rd  out  5  to regfile write address
wd  out  XLEN  to regfile write data

Behaviour:
- Reset (async, on rst high): FIFO empty, count=0, rd/wr pointers 0, pending all 0. Outputs follow: md_ready=1, reg_write=0, rd=0, wd=0, all stalls 0.
- Write-port mux (combinational):
  - core_we=1 and core_rd!=0: drive core_rd/core_wd, reg_write=1. FIFO head held.
  - Otherwise, FIFO non-empty: drive head rd/wd, reg_write=1, pop at clock edge.
  - Otherwise: reg_write=0, rd=0, wd=0.
- A core write to x0 counts as an idle slot, so the FIFO drains in that cycle.
- Enqueue:
  - Accept on md_valid && md_ready at the clock edge.
  - md_rd==0 results are accepted and dropped (not enqueued).
  - No bypass: an accepted result reaches the write port no earlier than the next cycle.
- Simultaneous push and pop: allowed. Count is unchanged, and md_ready stays as the pre-edge !full.
- Full: md_ready=0. md_valid in that cycle is ignored; the mul/div unit holds its result.
- Pointers wrap modulo DEPTH. Count ranges 0..DEPTH.
- Scoreboard:
  - Set pending[issue_rd] at the edge when issue_valid && issue_rd!=0 && !issue_stall.
  - Clear pending[rd] at the edge when a FIFO entry is popped to the write port.
  - If a set and a clear hit the same index in one cycle, set wins. This cannot legally occur because of issue_stall, but the RTL must still define it.
  - pending[0] is constant 0.
- Stalls: combinational from current pending state. A clear takes effect the following cycle; there is no same-cycle forwarding.
- Core writes never touch the scoreboard.
- Reset mid-operation: FIFO contents and pending bits are discarded immediately. Outputs return to reset values asynchronously.

Decomposition:
- Shared package rv_pkg:
  - XLEN and NREGS constants.
  - REG_X0 = 5'd0.
  - Typedef for a writeback bundle {rd[4:0], wd[XLEN-1:0]}.
- One sub-module: wb_fifo (DEPTH x bundle, push/pop/full/empty/count, async active-high reset).
- The arbiter mux and the scoreboard live in regfile_wb_arbiter.

Test Plan:
- Reset then idle: rst pulse mid-run with FIFO holding 2 entries -> immediately reg_write=0, md_ready=1, pending=0. No write occurs after release.
- Issue and drain: issue rd=7 -> raw_stall=1 for rs1=7. md result {7, 42} accepted at cycle N with core idle -> write x7=42 at cycle N+1. raw_stall drops at N+2.
- Core priority: core_we=1 (rd=3, wd=5) for 3 cycles while FIFO holds {10, 99} -> x3 written each cycle. x10=99 written on the first cycle core_we=0.
- Full backpressure: DEPTH=2, core_we held 1, three md results offered -> first two accepted, md_ready=0 for the third. The third is accepted in the cycle after the first pop.
- Hazards: pending x5 -> issue_rd=5 gives issue_stall=1 and no set. core_we rd=5 gives waw_stall=1. rs2=5 gives raw_stall=1.
- x0 handling: md result with rd=0 is dropped, count unchanged. A core write to x0 with FIFO non-empty lets the FIFO head drain in that cycle.
